// File: rtl/accbuf_drain.sv
// accbuf_drain: reader side of one accbuf channel. Follows the writer's
// pointer, reads committed entries through the BRAM read port and streams
// them out as a valid/ready stream with tlast.
//
// Ports:
//   clk, reset          DSP clock, synchronous active-high reset
//   stb_start, nread    start strobe and requested entry count
//   wr_ptr, resetacc    writer pointer and writer pointer-reset request
//   rd_en/rd_addr/rd_data  BRAM read port (data RDLAT cycles after rd_en)
//   m_tdata/m_tvalid/m_tready/m_tlast  output stream
//   busy, done, aborted, clamped, rdcnt  status
module accbuf_drain #(
   parameter int unsigned ADDRWIDTH = 12,
   parameter int unsigned DATAWIDTH = 64,
   parameter int unsigned RDLAT     = 2,
   parameter int unsigned FIFODEPTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stb_start,
   input  logic [ADDRWIDTH:0]   nread,
   input  logic [ADDRWIDTH-1:0] wr_ptr,
   input  logic                 resetacc,
   output logic                 rd_en,
   output logic [ADDRWIDTH-1:0] rd_addr,
   input  logic [DATAWIDTH-1:0] rd_data,
   output logic [DATAWIDTH-1:0] m_tdata,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 clamped,
   output logic [ADDRWIDTH:0]   rdcnt
);

   localparam int unsigned AW1 = ADDRWIDTH + 1;
   localparam int unsigned FAW = $clog2(FIFODEPTH);
   localparam int unsigned CW  = FAW + 1;
   // The all-ones address is never drained: the writer parks there.
   localparam logic [ADDRWIDTH:0] MAX_TGT = {1'b0, {ADDRWIDTH{1'b1}}};

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                 state;
   logic [ADDRWIDTH:0]     target;
   logic [ADDRWIDTH:0]     rd_ptr;
   logic [RDLAT-1:0]       vld;
   logic [RDLAT-1:0]       vld_next;
   logic [DATAWIDTH-1:0]   fifo_mem [FIFODEPTH];
   logic [FAW-1:0]         wr_idx;
   logic [FAW-1:0]         rd_idx;
   logic [CW-1:0]          fifo_count;
   logic                   start_c;
   logic                   abort_c;
   logic                   push_c;
   logic                   pop_c;
   logic                   last_c;
   logic                   issue_c;
   logic [ADDRWIDTH:0]     start_tgt;
   int unsigned            occ;

   // Stream side is a direct view of the FIFO head; gated off outside RUN.
   assign m_tvalid = (state == RUN) & (fifo_count != '0);
   assign m_tdata  = m_tvalid ? fifo_mem[rd_idx] : '0;
   assign m_tlast  = m_tvalid & (rdcnt == target - AW1'(1));

   // Issue, credit and transition decisions for the coming edge.
   always_comb begin
      start_c   = (state == IDLE) & stb_start;
      start_tgt = (nread > MAX_TGT) ? MAX_TGT : nread;
      abort_c   = (state == RUN) & (resetacc | ({1'b0, wr_ptr} < rd_ptr));
      pop_c     = m_tvalid & m_tready;
      push_c    = (state == RUN) & vld[RDLAT-1];
      last_c    = pop_c & m_tlast;
      // The read launched this cycle (rd_en) enters the tracker at the edge.
      vld_next  = RDLAT'({vld, rd_en});
      // Occupancy after this edge: FIFO minus pop, plus every read in flight.
      occ = 32'(fifo_count) + 32'(rd_en) - 32'(pop_c);
      for (int i = 0; i < int'(RDLAT); i++) begin
         occ = occ + 32'(vld[i]);
      end
      issue_c = 1'b0;
      if (start_c) begin
         issue_c = (start_tgt != '0) & (wr_ptr != '0);
      end else if ((state == RUN) & ~abort_c) begin
         issue_c = (rd_ptr < target) & (rd_ptr < {1'b0, wr_ptr}) &
                   (occ < FIFODEPTH);
      end
   end

   // FIFO storage, no reset needed.
   always_ff @(posedge clk) begin
      if (push_c) fifo_mem[wr_idx] <= rd_data;
   end

   // Control FSM, read issue, in-flight tracker, FIFO pointers and status.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         target     <= '0;
         rd_ptr     <= '0;
         vld        <= '0;
         wr_idx     <= '0;
         rd_idx     <= '0;
         fifo_count <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         clamped    <= 1'b0;
         rdcnt      <= '0;
      end else begin
         vld   <= vld_next;
         rd_en <= issue_c;
         done  <= 1'b0;

         if (issue_c) rd_addr <= start_c ? '0 : rd_ptr[ADDRWIDTH-1:0];

         if (start_c)      rd_ptr <= AW1'(issue_c);
         else if (issue_c) rd_ptr <= rd_ptr + AW1'(1);

         if (start_c)    rdcnt <= '0;
         else if (pop_c) rdcnt <= rdcnt + AW1'(1);

         // FIFO only holds data while draining; anything else empties it.
         if ((state != RUN) | abort_c) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_count <= '0;
         end else begin
            wr_idx     <= wr_idx + FAW'(push_c);
            rd_idx     <= rd_idx + FAW'(pop_c);
            fifo_count <= fifo_count + CW'(push_c) - CW'(pop_c);
         end

         case (state)
            IDLE: begin
               if (stb_start) begin
                  target  <= start_tgt;
                  clamped <= (nread > MAX_TGT);
                  aborted <= 1'b0;
                  busy    <= 1'b1;
                  if (start_tgt == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (abort_c) begin
                  state   <= FLUSH;
                  aborted <= 1'b1;
               end else if (last_c) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            FLUSH: begin
               // Leave once the last outstanding read has drained out.
               if (vld_next == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accbuf_drain.sv
// Bench for accbuf_drain: BRAM model with RDLAT pipeline, directed drains
// with randomized ready/data, reference expectations derived from the
// drain rules (target clamp, address order, tlast, done timing).
module tb_accbuf_drain;

   localparam int unsigned AW  = 7;
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned DW  = 64;
   localparam int unsigned RL  = 2;
   localparam int unsigned FD  = 8;
   localparam int          MAXT = (1 << AW) - 1;

   logic           clk = 1'b0;
   logic           reset, stb_start, resetacc, m_tready;
   logic [AW:0]    nread;
   logic [AW-1:0]  wr_ptr;
   logic           rd_en, m_tvalid, m_tlast, busy, done, aborted, clamped;
   logic [AW-1:0]  rd_addr;
   logic [DW-1:0]  rd_data, m_tdata;
   logic [AW:0]    rdcnt;

   logic [31:0]    salt;
   logic [DW-1:0]  pipe [RL];
   int             n_assert = 0;
   int             n_fail   = 0;

   always #5 clk = ~clk;

   accbuf_drain #(
      .ADDRWIDTH(AW), .DATAWIDTH(DW), .RDLAT(RL), .FIFODEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .stb_start(stb_start), .nread(nread),
      .wr_ptr(wr_ptr), .resetacc(resetacc), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done),
      .aborted(aborted), .clamped(clamped), .rdcnt(rdcnt)
   );

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {salt + 32'(a) * 32'h9e3779b9, 32'(a)};
   endfunction

   // BRAM read port: content word(addr), garbage when not enabled.
   always @(posedge clk) begin
      pipe[0] <= rd_en ? word(rd_addr) : {$urandom, $urandom};
      for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
   end
   assign rd_data = pipe[RL-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input string name, input int nrd, input int wp0,
                        input int wp_period, input int rdy_pct,
                        input int abort_at, input int reset_at, input bit restrike);
      int            tgt, cyc, beats, issued, first_v, last_hs, done_cyc, k;
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] held, exp_w;
      bit            stalled, data_ok, last_ok, addr_ok, stable_ok, fin, trig, saw;
      tgt = (nrd > MAXT) ? MAXT : nrd;
      salt = $urandom;
      exp_q.delete();
      for (int i = 0; i < tgt; i++) exp_q.push_back(word(AW'(i)));
      beats = 0; issued = 0; first_v = -1; last_hs = -1; done_cyc = -1;
      stalled = 0; data_ok = 1; last_ok = 1; addr_ok = 1; stable_ok = 1;
      fin = 0; trig = 0; held = '0;

      wr_ptr = AW'(wp0); nread = AW1'(nrd); m_tready = 1'b0; stb_start = 1'b1;
      @(posedge clk); #1;
      stb_start = 1'b0;
      check({name, "_clamped"}, 64'(clamped), 64'(nrd > MAXT));
      check({name, "_aborted0"}, 64'(aborted), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd1);

      cyc = 0;
      while (!fin && !trig && cyc < 3000) begin
         if (rd_en) begin
            if (rd_addr !== AW'(issued) || rd_addr >= wr_ptr) addr_ok = 0;
            issued++;
         end
         if (stalled && (!m_tvalid || m_tdata !== held)) stable_ok = 0;
         if (m_tvalid && first_v < 0) first_v = cyc;
         if (!m_tvalid && m_tlast) last_ok = 0;
         if (done) begin
            done_cyc = cyc;
            fin = 1;
         end else if ((abort_at >= 0 && beats == abort_at) ||
                      (reset_at >= 0 && beats == reset_at)) begin
            m_tready = 1'b0;
            if (abort_at >= 0) resetacc = 1'b1;
            else reset = 1'b1;
            trig = 1;
            @(posedge clk); #1;
         end else begin
            m_tready = (int'($urandom_range(99)) < rdy_pct);
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) data_ok = 0;
               else begin
                  exp_w = exp_q.pop_front();
                  if (m_tdata !== exp_w) data_ok = 0;
               end
               if (m_tlast !== (beats == tgt - 1)) last_ok = 0;
               if (beats == tgt - 1) last_hs = cyc;
               beats++;
            end
            stalled = m_tvalid && !m_tready;
            held = m_tdata;
            stb_start = restrike && cyc == 3;
            nread = (restrike && cyc == 3) ? AW1'(1) : AW1'(nrd);
            if (wp_period > 0 && cyc % wp_period == wp_period - 1 && int'(wr_ptr) < MAXT)
               wr_ptr = wr_ptr + AW'(1);
            @(posedge clk); #1;
            cyc++;
         end
      end

      check({name, "_addr_order"}, 64'(addr_ok), 64'd1);
      check({name, "_data"}, 64'(data_ok), 64'd1);
      check({name, "_stable"}, 64'(stable_ok), 64'd1);

      if (abort_at >= 0) begin
         resetacc = 1'b0;
         check({name, "_tvalid_drop"}, 64'(m_tvalid), 64'd0);
         check({name, "_aborted"}, 64'(aborted), 64'd1);
         check({name, "_rdcnt"}, 64'(rdcnt), 64'(abort_at));
         saw = done; k = 0;
         while (busy && k < int'(RL)) begin
            @(posedge clk); #1;
            k++;
            saw = saw | done;
         end
         check({name, "_idle"}, 64'(busy), 64'd0);
         check({name, "_nodone"}, 64'(saw), 64'd0);
         check({name, "_sticky"}, 64'(aborted), 64'd1);
      end else if (reset_at >= 0) begin
         reset = 1'b0;
         check({name, "_outs"}, {57'd0, rd_en, m_tvalid, m_tlast, busy, done, aborted, clamped}, 64'd0);
         check({name, "_addr_cnt"}, {48'd0, 8'(rd_addr), 8'(rdcnt)}, 64'd0);
         check({name, "_tdata"}, 64'(m_tdata), 64'd0);
         saw = 0;
         repeat (8) begin
            @(posedge clk); #1;
            saw = saw | rd_en | m_tvalid | done;
         end
         check({name, "_quiet"}, 64'(saw), 64'd0);
      end else begin
         check({name, "_beats"}, 64'(beats), 64'(tgt));
         check({name, "_tlast"}, 64'(last_ok), 64'd1);
         check({name, "_done_time"}, 64'(done_cyc), 64'((tgt == 0) ? 0 : last_hs + 1));
         if (tgt > 0 && wp0 > 0)
            check({name, "_latency"}, 64'(first_v), 64'(RL + 1));
         if (tgt > 0 && wp0 >= tgt && rdy_pct == 100)
            check({name, "_throughput"}, 64'(last_hs - first_v), 64'(tgt - 1));
         @(posedge clk); #1;
         check({name, "_end"}, {62'd0, busy, done}, 64'd0);
         check({name, "_rdcnt"}, 64'(rdcnt), 64'(tgt));
      end
   endtask

   initial begin
      int n;
      reset = 1'b1; stb_start = 1'b0; resetacc = 1'b0; m_tready = 1'b0;
      nread = '0; wr_ptr = '0; salt = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {57'd0, rd_en, m_tvalid, m_tlast, busy, done, aborted, clamped}, 64'd0);
      check("reset_vals", {48'd0, 8'(rd_addr), 8'(rdcnt)}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      drain("basic", 16, 16, 0, 100, -1, -1, 1'b0);
      drain("trail", 8, 0, 5, 100, -1, -1, 1'b1);
      drain("bp", 64, 64, 0, 30, -1, -1, 1'b0);
      drain("abort", 32, 32, 0, 100, 10, -1, 1'b0);
      drain("zero", 0, 5, 0, 100, -1, -1, 1'b0);
      drain("clamp", 200, 127, 0, 100, -1, -1, 1'b0);
      drain("rst", 32, 32, 0, 100, -1, 5, 1'b0);
      n = int'($urandom_range(1, 40));
      drain("rand", n, n + int'($urandom_range(0, 20)), 0, 60, -1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/accbuf_drain.md
Name: accbuf_drain

Overview:
- Reader side of the per-channel accumulator buffer (accbuf). The DSP core writes one shot result per accvalid and exposes its write pointer.
- This block follows that write pointer. It reads committed entries out of the BRAM read port and streams them out as a valid/ready stream with tlast, for host DMA or a packetizer.
- One instance per accbuf channel, placed in the dsp clock domain.

Parameters:
- ADDRWIDTH, 12, accbuf address width; equals ACCBUF_W_ADDRWIDTH.
- DATAWIDTH, 64, accbuf word width; {accx[31:0], accy[31:0]}.
- RDLAT, 2, BRAM read latency in cycles, from rd_en/rd_addr to rd_data valid; range 1..4.
- FIFODEPTH, 8, output FIFO depth; must be >= RDLAT+2, power of 2.

Ports:
- clk  in  1  DSP clock.
- reset  in  1  synchronous, active-high reset.
- stb_start  in  1  1-cycle strobe; begins a drain of nread entries from address 0.
- nread  in  ADDRWIDTH+1  number of entries to drain; sampled at stb_start.
- wr_ptr  in  ADDRWIDTH  accbuf write pointer (addr_accbuf_mon*); entries at addr < wr_ptr are committed.
- resetacc  in  1  level signal; the writer's pointer-reset request.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  ADDRWIDTH  BRAM read address.
- rd_data  in  DATAWIDTH  BRAM read data, valid RDLAT cycles after rd_en.
- m_tdata  out  DATAWIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on the final beat of a drain.
- busy  out  1  high while state != IDLE.
- done  out  1  1-cycle pulse when a drain completes.
- aborted  out  1  sticky; cleared at the next stb_start.
- clamped  out  1  sticky; nread exceeded the reachable depth; cleared at the next stb_start.
- rdcnt  out  ADDRWIDTH+1  beats accepted downstream in the current drain.

Behaviour:
- Reset: all outputs go to 0, state = IDLE, FIFO emptied, in-flight reads discarded.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on stb_start:
  - target = min(nread, 2^ADDRWIDTH-1); clamped = (nread > 2^ADDRWIDTH-1).
  - rd_ptr = 0, issued = 0, rdcnt = 0, aborted = 0.
  - The all-ones address is excluded because the writer locks there and overwrites it.
- IDLE -> DONE on stb_start with nread = 0: no beats are produced and done pulses one cycle later.
- stb_start outside IDLE is ignored.
- RUN, read issue: rd_en = 1 in a cycle iff all of the following hold:
  - issued < target;
  - rd_ptr < wr_ptr;
  - inflight + fifo_count < FIFODEPTH (credit check, so the FIFO never overflows).
  - On issue: rd_addr = rd_ptr, then rd_ptr and issued increment.
  - rd_addr holds its value when rd_en = 0.
- In-flight tracking:
  - A RDLAT-deep valid shift register tracks outstanding reads.
  - rd_data is pushed into the FIFO on the cycle the shift-register output is high.
  - inflight = popcount of the shift register.
- Output:
  - m_tvalid = FIFO not empty; m_tdata = FIFO head (first-word fall-through, no extra latency).
  - A pop occurs on m_tvalid & m_tready, and rdcnt increments.
  - m_tlast = m_tvalid & (rdcnt == target-1).
  - Push and pop in the same cycle leave fifo_count unchanged.
  - m_tdata is stable while m_tvalid & ~m_tready.
- RUN -> DONE on the handshake of the tlast beat. DONE lasts 1 cycle with done = 1, then IDLE.
- Latency: minimum RDLAT+1 cycles from stb_start (with wr_ptr > 0 and tready = 1) to the first m_tvalid. Sustained throughput is 1 beat/cycle.
- Abort, entered from RUN if either occurs:
  - resetacc = 1;
  - wr_ptr < rd_ptr (writer pointer went backward).
  - Action: aborted = 1 and state -> FLUSH.
- FLUSH:
  - No new reads are issued and m_tvalid is forced to 0.
  - Returning in-flight data is dropped and the FIFO is cleared.
  - Exit to IDLE once the shift register is empty, at most RDLAT cycles. done is not pulsed.
- wr_ptr stalls (writer slower than reader): reading stalls, and the block stays in RUN indefinitely.
- reset mid-RUN: immediate return to IDLE, no done, no tlast, no further rd_en.

Test Plan:
- Basic drain: wr_ptr=16, nread=16, tready=1, rd_data=addr -> 16 beats with data 0..15 back-to-back; tlast on beat 15; done one cycle after; first tvalid RDLAT+1 cycles after stb_start.
- Trailing writer: nread=8, wr_ptr increments by 1 every 5 cycles from 0 -> rd_en is never issued with rd_addr >= wr_ptr; 8 beats in order; done.
- Backpressure: wr_ptr=64, nread=64, tready random 30% -> no beat lost or duplicated; fifo_count <= FIFODEPTH throughout; m_tdata stable while stalled.
- Abort: resetacc asserted after 10 beats of a nread=32 drain -> m_tvalid drops next cycle; aborted=1; no done; busy returns to 0 within RDLAT+1 cycles; next stb_start clears aborted.
- Boundaries: nread=0 -> done pulse, zero beats. ADDRWIDTH=4, wr_ptr=15, nread=20 -> clamped=1, 15 beats (addr 0..14), tlast on addr 14.
- Sync reset mid-drain after 5 beats -> all outputs 0 on the following cycle; no rd_en afterward.
